multicycle_alu: RTL and testbench

Execute-stage ALU that consumes the 4-bit `Operation` code produced by the ALU controller and computes the result and branch decision for two operands. Logic, arithmetic, compare and branch operations finish in one cycle. Shifts are iterative, one bit per cycle, to save area. A valid/ready handshake on both sides lets the multicycle datapath control stall while a shift is in progress.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_shift_step.sv | 22 ++
 rtl/multicycle_alu.sv | 133 +++++++++++++
 tb/tb_multicycle_alu.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes and FSM states for the execute-stage ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SLL = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SUB = 4'b0110,
        OP_BEQ = 4'b1000,
        OP_BNE = 4'b1001,
        OP_SRA = 4'b1010,
        OP_SLT = 4'b1100,
        OP_BGE = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift of the accumulator; the op selects SLL, SRL or SRA.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_t            op_i,
    input  logic [WIDTH-1:0]   acc_i,
    output logic [WIDTH-1:0]   shifted_o
);

    always_comb begin
        shifted_o = acc_i;
        case (op_i)
            OP_SLL:  shifted_o = {acc_i[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted_o = {1'b0, acc_i[WIDTH-1:1]};
            OP_SRA:  shifted_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
            default: shifted_o = acc_i;
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logic/arith/compare/branch, iterative 1-bit/cycle shifts.
// Valid/ready on both sides; one operation in flight, result held in DONE until accepted.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Branch
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t       state_q, state_d;
    alu_op_t          op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             branch_q, branch_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] sc_result;
    logic             sc_branch;
    logic             signed_lt;
    logic [SHW-1:0]   shamt;

    assign shamt     = SrcB[SHW-1:0];
    assign signed_lt = $signed(SrcA) < $signed(SrcB);

    alu_shift_step #(.WIDTH(WIDTH)) u_shift_step (
        .op_i      (op_q),
        .acc_i     (acc_q),
        .shifted_o (shifted)
    );

    // Single-cycle datapath; a zero-amount shift simply passes A through.
    always_comb begin
        sc_result = '0;
        sc_branch = 1'b0;
        case (Operation)
            OP_AND: sc_result = SrcA & SrcB;
            OP_OR:  sc_result = SrcA | SrcB;
            OP_ADD: sc_result = SrcA + SrcB;
            OP_SUB: sc_result = SrcA - SrcB;
            OP_XOR: sc_result = SrcA ^ SrcB;
            OP_SLT: begin
                sc_result = {{(WIDTH-1){1'b0}}, signed_lt};
                sc_branch = signed_lt;
            end
            OP_BEQ: sc_branch = (SrcA == SrcB);
            OP_BNE: sc_branch = (SrcA != SrcB);
            OP_BGE: sc_branch = !signed_lt;
            OP_SLL, OP_SRL, OP_SRA: sc_result = SrcA;
            default: begin
                sc_result = '0;
                sc_branch = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        branch_d = branch_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = alu_op_t'(Operation);
                    if (is_shift(Operation) && (shamt != '0)) begin
                        acc_d   = SrcA;
                        cnt_d   = shamt;
                        state_d = SHIFT;
                    end else begin
                        result_d = sc_result;
                        branch_d = sc_branch;
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                acc_d = shifted;
                cnt_d = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
                if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
                    result_d = shifted;
                    branch_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_AND;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            branch_q <= branch_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign ALUResult = result_q;
    assign Branch    = branch_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: ops, shift latency, back-pressure, reset mid-shift.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Branch;

    int checks = 0;
    int errors = 0;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Branch    (Branch)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, measure latency, check, then retire it.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat,
                         input logic [31:0] exp_res, input logic exp_br);
        int lat;
        int wait_cyc;
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 100) begin
            step();
            wait_cyc++;
        end
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        out_ready = 1'b0;
        step();
        in_valid  = 1'b0;
        Operation = ~op;
        SrcA      = ~a;
        SrcB      = ~b;
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, ALUResult, exp_res);
        check({tag, "_branch"}, {31'b0, Branch}, {31'b0, exp_br});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_retired"}, {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        logic        stable;
        logic [31:0] held;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Operation = 4'b0000;
        SrcA      = '0;
        SrcB      = '0;
        step();
        step();
        reset = 1'b0;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", ALUResult, 32'd0);
        check("reset_branch", {31'b0, Branch}, 32'd0);

        do_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 1'b0);
        do_op("sub_wrap", 4'b0110, 32'h0, 32'h1, 0, 32'hFFFF_FFFF, 1'b0);
        do_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 32'h00F0_1200, 1'b0);
        do_op("or", 4'b0001, 32'hF000_0001, 32'h0000_0F10, 0, 32'hF000_0F11, 1'b0);
        do_op("xor", 4'b0100, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 32'hF0F0_0F0F, 1'b0);
        do_op("slt", 4'b1100, 32'hFFFF_FFFF, 32'h1, 0, 32'h1, 1'b1);
        do_op("bge", 4'b1101, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 1'b0);
        do_op("beq", 4'b1000, 32'h5, 32'h5, 0, 32'h0, 1'b1);
        do_op("bne", 4'b1001, 32'h5, 32'h5, 0, 32'h0, 1'b0);
        do_op("illegal", 4'b0111, 32'h1234_5678, 32'h1, 0, 32'h0, 1'b0);
        do_op("sra31", 4'b1010, 32'h8000_0000, 32'd31, 31, 32'hFFFF_FFFF, 1'b0);
        do_op("srl31", 4'b0101, 32'h8000_0000, 32'd31, 31, 32'h0000_0001, 1'b0);
        do_op("sll_n0", 4'b0011, 32'h1, 32'h20, 0, 32'h1, 1'b0);
        do_op("sll4", 4'b0011, 32'h1, 32'h4, 4, 32'h10, 1'b0);
        do_op("sra_hibits", 4'b1010, 32'hF000_0000, 32'hFFFF_FFE4, 4, 32'hFF00_0000, 1'b0);

        // Stall in DONE with a competing request on the input side.
        in_valid  = 1'b1;
        Operation = 4'b0100;
        SrcA      = 32'hF0F0_F0F0;
        SrcB      = 32'h0FF0_0FF0;
        step();
        Operation = 4'b0010;
        SrcA      = 32'd10;
        SrcB      = 32'd20;
        held      = ALUResult;
        check("bp_result", held, 32'hFF00_FF00);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!out_valid || in_ready || ALUResult !== 32'hFF00_FF00 || Branch !== 1'b0)
                stable = 1'b0;
        end
        check("bp_stable", {31'b0, stable}, 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_back_idle", {30'b0, out_valid, in_ready}, 32'b01);
        step();
        in_valid = 1'b0;
        check("bp_next_valid", {31'b0, out_valid}, 32'd1);
        check("bp_next_result", ALUResult, 32'd30);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset while a 20-bit shift has 7 steps left.
        in_valid  = 1'b1;
        Operation = 4'b0011;
        SrcA      = 32'h1;
        SrcB      = 32'd20;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 13; i++) step();
        check("mid_shift_busy", {30'b0, out_valid, in_ready}, 32'b00);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_shift_ready", {31'b0, in_ready}, 32'd1);
        check("rst_shift_valid", {31'b0, out_valid}, 32'd0);
        check("rst_shift_result", ALUResult, 32'd0);
        for (int i = 0; i < 10; i++) step();
        check("rst_shift_quiet", {31'b0, out_valid}, 32'd0);
        do_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 0, 32'd5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
